zorro_master_cycle_sequencer: RTL and testbench

Sequences Zorro III master bus cycles for the on-board SCSI controller once the bus arbiter has granted ownership (MYBUS_n low). It accepts one local cycle request at a time and drives FCS_n, READ, DOE and DS_n[3:0]. It then waits for a synchronised DTACK_n or BERR_n and returns a single-cycle completion or error pulse to the local side. It sits between the bus arbiter and the Zorro III control-line buffers.

---
 rtl/zorro_master_cycle_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_zorro_master_cycle_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/zorro_master_cycle_sequencer.sv
// zorro_master_cycle_sequencer
//
// Runs one Zorro III master bus cycle per local request once the arbiter has
// handed over the bus (MYBUS_n low). It drives the control strobes, waits for
// a synchronised DTACK_n or BERR_n, then returns a one-cycle ACK (with ERR on
// an error) to the local side.
//
// Parameters:
//   ADDR_SETUP     - cycles FCS_n is low before DOE/DS_n assert (1..7)
//   TIMEOUT_CYCLES - WAIT cycles before a forced error termination (1..255)
//
// Ports:
//   CLK      in   local bus clock
//   RESET    in   synchronous reset, active high
//   MYBUS_n  in   bus ownership from arbiter, active low
//   REQ      in   local cycle request (level, sampled only in idle)
//   RW       in   1 = read, 0 = write (latched with REQ)
//   BYTE_EN  in   byte lanes 3..0, active high (latched with REQ)
//   DTACK_n  in   Zorro III data acknowledge, asynchronous
//   BERR_n   in   Zorro III bus error, asynchronous
//   FCS_n    out  full cycle strobe
//   READ     out  Zorro READ line
//   DOE      out  data output enable
//   DS_n     out  data strobes 3..0
//   ACK      out  one-cycle pulse: cycle finished
//   ERR      out  one-cycle pulse with ACK: cycle ended in error
//   BUSY     out  high whenever the sequencer is not idle
//
// Build option:
//   ZMCS_TIMEOUT_EN - when defined, WAIT gives up after TIMEOUT_CYCLES and
//                     terminates with ERR; otherwise WAIT waits indefinitely.

module zorro_master_cycle_sequencer #(
  parameter int unsigned ADDR_SETUP     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       MYBUS_n,
  input  logic       REQ,
  input  logic       RW,
  input  logic [3:0] BYTE_EN,
  input  logic       DTACK_n,
  input  logic       BERR_n,
  output logic       FCS_n,
  output logic       READ,
  output logic       DOE,
  output logic [3:0] DS_n,
  output logic       ACK,
  output logic       ERR,
  output logic       BUSY
);

  if (ADDR_SETUP < 1 || ADDR_SETUP > 7) begin : g_bad_addr_setup
    $error("ADDR_SETUP must be in 1..7");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  localparam logic [2:0] SetupLast = 3'(ADDR_SETUP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StWait,
    StTerm
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] setup_cnt_q, setup_cnt_d;
  logic [3:0] be_q, be_d;
  logic       fcs_n_q, fcs_n_d;
  logic       read_q, read_d;
  logic       doe_q, doe_d;
  logic [3:0] ds_n_q, ds_n_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       busy_q;

`ifdef ZMCS_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  // Remembers that TERM was reached by timeout, so it need not wait for release.
  logic       tmo_hit_q, tmo_hit_d;
`endif

  // Two-flop synchronisers for the asynchronous bus responses (idle high).
  logic dtack_meta, dtack_s;
  logic berr_meta, berr_s;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dtack_meta <= 1'b1;
      dtack_s    <= 1'b1;
      berr_meta  <= 1'b1;
      berr_s     <= 1'b1;
    end else begin
      dtack_meta <= DTACK_n;
      dtack_s    <= dtack_meta;
      berr_meta  <= BERR_n;
      berr_s     <= berr_meta;
    end
  end

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    be_d        = be_q;
    fcs_n_d     = fcs_n_q;
    read_d      = read_q;
    doe_d       = doe_q;
    ds_n_d      = ds_n_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
`ifdef ZMCS_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_hit_d   = tmo_hit_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (REQ && !MYBUS_n) begin
          be_d = BYTE_EN;
          if (BYTE_EN == 4'h0) begin
            // Nothing to transfer: acknowledge without touching the bus.
            ack_d = 1'b1;
          end else begin
            state_d     = StAddr;
            setup_cnt_d = 3'd0;
            fcs_n_d     = 1'b0;
            read_d      = RW;
          end
        end
      end

      StAddr: begin
        if (setup_cnt_q == SetupLast) begin
          state_d = StData;
          doe_d   = 1'b1;
          ds_n_d  = ~be_q;
        end else begin
          setup_cnt_d = setup_cnt_q + 3'd1;
        end
      end

      StData: begin
        state_d = StWait;
`ifdef ZMCS_TIMEOUT_EN
        tmo_cnt_d = 8'd0;
        tmo_hit_d = 1'b0;
`endif
      end

      StWait: begin
        // BERR has priority over DTACK when both arrive together.
        if (!berr_s || !dtack_s) begin
          state_d = StTerm;
          fcs_n_d = 1'b1;
          doe_d   = 1'b0;
          ds_n_d  = 4'hF;
          ack_d   = 1'b1;
          err_d   = !berr_s;
        end
`ifdef ZMCS_TIMEOUT_EN
        else if (tmo_cnt_q == TimeoutLast) begin
          state_d   = StTerm;
          fcs_n_d   = 1'b1;
          doe_d     = 1'b0;
          ds_n_d    = 4'hF;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          tmo_hit_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end

      StTerm: begin
`ifdef ZMCS_TIMEOUT_EN
        if (tmo_hit_q || (dtack_s && berr_s)) begin
`else
        if (dtack_s && berr_s) begin
`endif
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      setup_cnt_q <= 3'd0;
      be_q        <= 4'h0;
      fcs_n_q     <= 1'b1;
      read_q      <= 1'b1;
      doe_q       <= 1'b0;
      ds_n_q      <= 4'hF;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ZMCS_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
      tmo_hit_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      be_q        <= be_d;
      fcs_n_q     <= fcs_n_d;
      read_q      <= read_d;
      doe_q       <= doe_d;
      ds_n_q      <= ds_n_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= (state_d != StIdle);
`ifdef ZMCS_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_hit_q   <= tmo_hit_d;
`endif
    end
  end

  assign FCS_n = fcs_n_q;
  assign READ  = read_q;
  assign DOE   = doe_q;
  assign DS_n  = ds_n_q;
  assign ACK   = ack_q;
  assign ERR   = err_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_zorro_master_cycle_sequencer.sv
// Self-checking bench for zorro_master_cycle_sequencer. Expected waveforms are
// derived from cycle arithmetic on each transaction (grant edge, setup length,
// response edge, release edge); inputs change and outputs are sampled on the
// falling clock edge.

module tb_zorro_master_cycle_sequencer;

  localparam int AS = 3;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mybus_n = 1'b1;
  logic       req = 1'b0;
  logic       rw = 1'b0;
  logic [3:0] byte_en = 4'h0;
  logic       dtack_n = 1'b1;
  logic       berr_n = 1'b1;
  logic       fcs_n, read, doe, ack, err, busy;
  logic [3:0] ds_n;

  int n_checks = 0;
  int n_errors = 0;

  zorro_master_cycle_sequencer #(
    .ADDR_SETUP    (AS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK    (clk),
    .RESET  (rst),
    .MYBUS_n(mybus_n),
    .REQ    (req),
    .RW     (rw),
    .BYTE_EN(byte_en),
    .DTACK_n(dtack_n),
    .BERR_n (berr_n),
    .FCS_n  (fcs_n),
    .READ   (read),
    .DOE    (doe),
    .DS_n   (ds_n),
    .ACK    (ack),
    .ERR    (err),
    .BUSY   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_fcs"}, 32'(fcs_n), 1);
    check_val({tag, "_read"}, 32'(read), 1);
    check_val({tag, "_doe"}, 32'(doe), 0);
    check_val({tag, "_ds"}, 32'(ds_n), 32'hF);
    check_val({tag, "_ack"}, 32'(ack), 0);
    check_val({tag, "_err"}, 32'(err), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
  endtask

  // kind: 0 DTACK, 1 BERR, 2 both together, 3 no response.
  // d: cycles after DS_n asserts before the response line is driven low.
  // hold: extra cycles the response stays low after ACK.
  // rst_at: cycle index (after grant) at which RESET is raised, -1 for none.
  task automatic run_txn(input bit t_rw, input logic [3:0] t_be, input int gdly,
                         input int d, input int kind, input int hold, input int rst_at);
    int k, a, idle_j, last_j;
    bit err_exp, drop_bus, active;
    logic [3:0] ds_act;
    k = AS + d + 1;      // edge at which the first synchroniser flop sees the response
    active = (t_be != 4'h0);
    ds_act = ~t_be;
    if (!active) begin
      a = 0; idle_j = 0; err_exp = 1'b0;
    end else if (kind == 3) begin
`ifdef ZMCS_TIMEOUT_EN
      a = AS + 1 + TO; idle_j = a + 1;
`else
      a = 1 << 20; idle_j = a;
`endif
      err_exp = 1'b1;
    end else begin
      a = k + 2; idle_j = a + hold + 3; err_exp = (kind != 0);
    end
    last_j = (rst_at >= 0) ? rst_at + 1 : (active ? idle_j : 1);
    drop_bus = 1'($urandom_range(0, 1));

    req = 1'b1; rw = t_rw; byte_en = t_be; mybus_n = (gdly > 0);
    for (int g = 0; g < gdly; g++) begin
      @(negedge clk);
      check_val("nogrant_fcs", 32'(fcs_n), 1);
      check_val("nogrant_ds", 32'(ds_n), 32'hF);
      check_val("nogrant_busy", 32'(busy), 0);
      if (g == gdly - 1) mybus_n = 1'b0;
    end

    for (int j = 0; j <= last_j; j++) begin
      @(negedge clk);
      if (rst_at >= 0 && j == rst_at + 1) begin
        check_reset_outputs("midreset");
        rst = 1'b0;
      end else begin
        check_val("fcs", 32'(fcs_n), (active && j < a) ? 1'b0 : 1'b1);
        check_val("doe", 32'(doe), (active && j >= AS && j < a) ? 1'b1 : 1'b0);
        check_val("ds", 32'(ds_n), (active && j >= AS && j < a) ? 32'(ds_act) : 32'hF);
        check_val("ack", 32'(ack), (j == a) ? 1'b1 : 1'b0);
        check_val("err", 32'(err), (j == a && err_exp) ? 1'b1 : 1'b0);
        check_val("busy", 32'(busy), (active && j < idle_j) ? 1'b1 : 1'b0);
        if (active && j < a) check_val("read", 32'(read), 32'(t_rw));
      end
      // Inputs for the next rising edge.
      if (j == 0 && active && drop_bus) mybus_n = 1'b1;
      if (kind < 3 && active && j == k - 1) begin
        dtack_n = (kind == 1);
        berr_n  = (kind == 0);
      end
      if (j == a) req = 1'b0;
      if (kind < 3 && j == a + hold) begin
        dtack_n = 1'b1;
        berr_n  = 1'b1;
      end
      if (j == rst_at) begin
        rst = 1'b1;
        req = 1'b0;
      end
    end
    req = 1'b0; mybus_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Read, all lanes.
    run_txn(1'b1, 4'hF, 0, 2, 0, 0, -1);
    // Write, alternate lanes.
    run_txn(1'b0, 4'b0101, 0, 1, 0, 1, -1);
    // DTACK and BERR together, held a while.
    run_txn(1'b1, 4'h3, 0, 0, 2, 2, -1);
    // BERR only.
    run_txn(1'b0, 4'h8, 1, 3, 1, 0, -1);
    // REQ waiting 10 cycles for grant.
    run_txn(1'b1, 4'hC, 10, 1, 0, 0, -1);
    // Zero byte enables: ACK only.
    run_txn(1'b1, 4'h0, 0, 0, 0, 0, -1);

    // Zero byte enables with REQ held past ACK: a second ACK follows.
    req = 1'b1; byte_en = 4'h0; mybus_n = 1'b0;
    @(negedge clk);
    check_val("b2b_ack0", 32'(ack), 1);
    @(negedge clk);
    check_val("b2b_ack1", 32'(ack), 1);
    req = 1'b0;
    @(negedge clk);
    check_val("b2b_ack2", 32'(ack), 0);
    check_val("b2b_fcs", 32'(fcs_n), 1);
    mybus_n = 1'b1;

`ifdef ZMCS_TIMEOUT_EN
    // No response: forced error termination.
    run_txn(1'b1, 4'hF, 0, 0, 3, 0, -1);
    // Reset while in WAIT.
    run_txn(1'b0, 4'h6, 0, 0, 3, 0, AS + 3);
`else
    // No response: stays busy for 1000 cycles, then reset recovers it.
    run_txn(1'b1, 4'hF, 0, 0, 3, 0, 1000);
`endif
    @(negedge clk);
    check_reset_outputs("after_midreset");

    // Randomized back-to-back transactions.
    for (int t = 0; t < 30; t++) begin
      run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
              $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
